// File: rtl/iic_eeprom_slave.sv
// 24Cxx-style I2C serial-EEPROM responder with a 256-byte array.
// SCL/SDA are oversampled on sclk. The responder supports byte and page
// writes, current-address reads and random reads. SDA is driven open-drain
// through sda_oe.
module iic_eeprom_slave #(
  parameter logic [3:0]  DEV_ID   = 4'b1010,
  parameter int unsigned MEM_AW   = 8,
  parameter int unsigned PAGE_AW  = 3,
  parameter logic [7:0]  INIT_VAL = 8'hFF
) (
  input  logic sclk,
  input  logic reset,
  input  logic scl_i,
  input  logic sda_i,
  input  logic a0,
  input  logic a1,
  input  logic a2,
  input  logic wp,
  output logic sda_oe,
  output logic busy,
  output logic wr_pulse
);

  localparam int unsigned DEPTH = 2 ** MEM_AW;

  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, DEV_ACK, WORD_ADDR, WORD_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK
  } state_t;

  logic [1:0]        scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic              scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;
  state_t            state_q, state_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              rw_q, rw_d;
  logic [MEM_AW-1:0] ptr_q, ptr_d;
  logic              sda_oe_q, sda_oe_d;
  logic              busy_q, busy_d;
  logic              wr_pulse_q, wr_pulse_d;
  logic [7:0]        mem_q [DEPTH];
  logic              mem_we;
  logic [7:0]        rd_byte;
  logic [PAGE_AW-1:0] page_nxt;

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det, addr_match;

  assign scl_s      = scl_sync_q[1];
  assign sda_s      = sda_sync_q[1];
  assign scl_rise   = scl_s & ~scl_hist_q;
  assign scl_fall   = ~scl_s & scl_hist_q;
  assign start_det  = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
  assign stop_det   = scl_s & scl_hist_q & ~sda_hist_q & sda_s;
  assign addr_match = (shift_q[7:1] == {DEV_ID, a2, a1, a0});
  assign rd_byte    = mem_q[ptr_q];
  assign page_nxt   = ptr_q[PAGE_AW-1:0] + PAGE_AW'(1);

  assign sda_oe   = sda_oe_q;
  assign busy     = busy_q;
  assign wr_pulse = wr_pulse_q;

  // Synchronizer shift and history next values.
  always_comb begin
    scl_sync_d = {scl_sync_q[0], scl_i};
    sda_sync_d = {sda_sync_q[0], sda_i};
    scl_hist_d = scl_sync_q[1];
    sda_hist_d = sda_sync_q[1];
  end

  // Two-flop synchronizers plus history flops; reset to idle-bus level.
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
    end
  end

  // Protocol FSM: bits are sampled on SCL rise, and SDA changes on SCL fall.
  // A byte is complete when bit_cnt reaches 8 and is acted on at the next fall,
  // so a STOP that arrives mid-byte leaves memory and pointer untouched.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rw_d       = rw_q;
    ptr_d      = ptr_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wr_pulse_d = 1'b0;
    mem_we     = 1'b0;
    if (start_det) begin
      state_d   = DEV_ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b1;
    end else if (stop_det) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        DEV_ADDR, WORD_ADDR, WR_DATA: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = '0;
            case (state_q)
              DEV_ADDR: begin
                rw_d = shift_q[0];
                if (addr_match) begin
                  state_d  = DEV_ACK;
                  sda_oe_d = 1'b1;
                end else begin
                  state_d = IDLE;
                end
              end
              WORD_ADDR: begin
                ptr_d    = MEM_AW'(shift_q);
                sda_oe_d = 1'b1;
                state_d  = WORD_ACK;
              end
              default: begin
                if (!wp) begin
                  mem_we     = 1'b1;
                  wr_pulse_d = 1'b1;
                  sda_oe_d   = 1'b1;
                end else begin
                  sda_oe_d = 1'b0;
                end
                ptr_d[PAGE_AW-1:0] = page_nxt;
                state_d = WR_ACK;
              end
            endcase
          end
        end
        DEV_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = '0;
            if (rw_q) begin
              state_d  = RD_DATA;
              shift_d  = rd_byte;
              sda_oe_d = ~rd_byte[7];
            end else begin
              state_d  = WORD_ADDR;
              sda_oe_d = 1'b0;
            end
          end
        end
        WORD_ACK, WR_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            state_d   = WR_DATA;
          end
        end
        RD_DATA: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            ptr_d     = ptr_q + MEM_AW'(1);
            state_d   = RD_ACK;
          end else if (scl_fall && bit_cnt_q != 4'd0) begin
            shift_d  = {shift_q[6:0], 1'b0};
            sda_oe_d = ~shift_q[6];
          end
        end
        RD_ACK: begin
          // bit_cnt records that the master ACKed; the next byte starts at the fall.
          if (scl_rise && bit_cnt_q == 4'd0) begin
            if (!sda_s) bit_cnt_d = 4'd1;
            else        state_d   = IDLE;
          end else if (scl_fall && bit_cnt_q == 4'd1) begin
            bit_cnt_d = '0;
            state_d   = RD_DATA;
            shift_d   = rd_byte;
            sda_oe_d  = ~rd_byte[7];
          end
        end
        default: ;
      endcase
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rw_q       <= 1'b0;
      ptr_q      <= '0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_pulse_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rw_q       <= rw_d;
      ptr_q      <= ptr_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  // Byte array: every byte reinitialised on reset, written at the committed pointer.
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= INIT_VAL;
    end else if (mem_we) begin
      mem_q[ptr_q] <= shift_q;
    end
  end

endmodule

// File: tb/tb_iic_eeprom_slave.sv
// Directed bench for iic_eeprom_slave: a bit-banged I2C master with open-drain SDA.
module tb_iic_eeprom_slave;

  logic sclk = 1'b0;
  logic reset, scl_m, sda_m, a0, a1, a2, wp;
  logic sda_oe, busy, wr_pulse;
  logic sda_line;

  int compared   = 0;
  int mismatched = 0;
  int pulse_cnt  = 0;
  bit oe_seen    = 1'b0;

  assign sda_line = sda_m & ~sda_oe;

  always #5 sclk = ~sclk;

  always @(negedge sclk) begin
    if (wr_pulse) pulse_cnt++;
    if (sda_oe) oe_seen = 1'b1;
  end

  iic_eeprom_slave #(.DEV_ID(4'b1010), .MEM_AW(8), .PAGE_AW(3), .INIT_VAL(8'hFF)) dut (
    .sclk(sclk), .reset(reset), .scl_i(scl_m), .sda_i(sda_line),
    .a0(a0), .a1(a1), .a2(a2), .wp(wp),
    .sda_oe(sda_oe), .busy(busy), .wr_pulse(wr_pulse)
  );

  task automatic q();
    repeat (10) @(negedge sclk);
  endtask

  task automatic do_reset();
    scl_m = 1'b1; sda_m = 1'b1; reset = 1'b1;
    repeat (3) @(negedge sclk);
    reset = 1'b0;
    repeat (5) @(negedge sclk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; q(); scl_m = 1'b1; q(); sda_m = 1'b0; q(); scl_m = 1'b0; q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; q(); scl_m = 1'b1; q(); sda_m = 1'b1; q();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; q(); scl_m = 1'b1; q(); q(); scl_m = 1'b0; q();
    end
    sda_m = 1'b1; q(); scl_m = 1'b1; q();
    ack = ~sda_line;
    q(); scl_m = 1'b0; q();
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] b);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      q(); scl_m = 1'b1; q(); b[i] = sda_line; q(); scl_m = 1'b0;
    end
    q(); sda_m = ~ack; q(); scl_m = 1'b1; q(); q(); scl_m = 1'b0; q();
    sda_m = 1'b1;
  endtask

  task automatic test_reset();
    wp = 1'b0; {a2, a1, a0} = 3'b000;
    do_reset();
    compared++; if (sda_oe !== 1'b0) begin mismatched++; $display("FAIL reset_sda_oe: got %b expected 0", sda_oe); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b expected 0", busy); end
    compared++; if (wr_pulse !== 1'b0) begin mismatched++; $display("FAIL reset_wr_pulse: got %b expected 0", wr_pulse); end
    compared++; if (dut.ptr_q !== 8'h00) begin mismatched++; $display("FAIL reset_ptr: got %h expected 00", dut.ptr_q); end
    compared++; if (dut.mem_q[8'h12] !== 8'hFF) begin mismatched++; $display("FAIL reset_mem: got %h expected ff", dut.mem_q[8'h12]); end
  endtask

  task automatic test_byte_write();
    logic k0, k1, k2;
    int p0;
    p0 = pulse_cnt;
    i2c_start();
    write_byte(8'hA0, k0); write_byte(8'h12, k1); write_byte(8'h5C, k2);
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL bw_busy_mid: got %b expected 1", busy); end
    i2c_stop(); q();
    compared++; if ({k0, k1, k2} !== 3'b111) begin mismatched++; $display("FAIL bw_acks: got %b expected 111", {k0, k1, k2}); end
    compared++; if (pulse_cnt - p0 !== 1) begin mismatched++; $display("FAIL bw_pulses: got %0d expected 1", pulse_cnt - p0); end
    compared++; if (dut.mem_q[8'h12] !== 8'h5C) begin mismatched++; $display("FAIL bw_mem: got %h expected 5c", dut.mem_q[8'h12]); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL bw_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_random_read();
    logic k0, k1, k2;
    logic [7:0] d;
    i2c_start(); write_byte(8'hA0, k0); write_byte(8'h12, k1);
    i2c_start(); write_byte(8'hA1, k2);
    read_byte(1'b0, d);
    q();
    compared++; if (sda_oe !== 1'b0) begin mismatched++; $display("FAIL rr_release: got %b expected 0", sda_oe); end
    i2c_stop(); q();
    compared++; if ({k0, k1, k2} !== 3'b111) begin mismatched++; $display("FAIL rr_acks: got %b expected 111", {k0, k1, k2}); end
    compared++; if (d !== 8'h5C) begin mismatched++; $display("FAIL rr_data: got %h expected 5c", d); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rr_busy: got %b expected 0", busy); end
  endtask

  task automatic test_page_wrap();
    logic k;
    logic [7:0] d, exp_d;
    int p0;
    p0 = pulse_cnt;
    i2c_start(); write_byte(8'hA0, k); write_byte(8'h3E, k);
    for (int i = 0; i < 10; i++) begin
      write_byte(8'(i + 1), k);
      compared++; if (k !== 1'b1) begin mismatched++; $display("FAIL pw_ack[%0d]: got %b expected 1", i, k); end
    end
    i2c_stop(); q();
    compared++; if (pulse_cnt - p0 !== 10) begin mismatched++; $display("FAIL pw_pulses: got %0d expected 10", pulse_cnt - p0); end
    i2c_start(); write_byte(8'hA0, k); write_byte(8'h38, k);
    i2c_start(); write_byte(8'hA1, k);
    for (int i = 0; i < 9; i++) begin
      read_byte(i != 8, d);
      exp_d = (i == 8) ? 8'hFF : 8'(i + 3);
      compared++; if (d !== exp_d) begin mismatched++; $display("FAIL pw_read[%0d]: got %h expected %h", i, d, exp_d); end
    end
    i2c_stop(); q();
  endtask

  task automatic test_wp();
    logic k0, k1, k2;
    logic [7:0] d;
    int p0;
    p0 = pulse_cnt;
    wp = 1'b1;
    i2c_start(); write_byte(8'hA0, k0); write_byte(8'h20, k1); write_byte(8'h77, k2); i2c_stop(); q();
    compared++; if ({k0, k1, k2} !== 3'b110) begin mismatched++; $display("FAIL wp_acks: got %b expected 110", {k0, k1, k2}); end
    compared++; if (pulse_cnt - p0 !== 0) begin mismatched++; $display("FAIL wp_pulses: got %0d expected 0", pulse_cnt - p0); end
    wp = 1'b0;
    i2c_start(); write_byte(8'hA0, k0); write_byte(8'h20, k1);
    i2c_start(); write_byte(8'hA1, k2); read_byte(1'b0, d); i2c_stop(); q();
    compared++; if (d !== 8'hFF) begin mismatched++; $display("FAIL wp_mem: got %h expected ff", d); end
  endtask

  task automatic test_mismatch();
    logic k0, k1;
    {a2, a1, a0} = 3'b101;
    q();
    oe_seen = 1'b0;
    i2c_start(); write_byte(8'hA0, k0); write_byte(8'h12, k1); i2c_stop(); q();
    compared++; if (k0 !== 1'b0) begin mismatched++; $display("FAIL mm_nack: got %b expected 0", k0); end
    compared++; if (oe_seen !== 1'b0) begin mismatched++; $display("FAIL mm_oe_seen: got %b expected 0", oe_seen); end
    i2c_start(); write_byte(8'hAA, k0); i2c_stop(); q();
    compared++; if (k0 !== 1'b1) begin mismatched++; $display("FAIL mm_match_ack: got %b expected 1", k0); end
    {a2, a1, a0} = 3'b000;
    q();
  endtask

  task automatic test_read_wrap();
    logic k;
    logic [7:0] d0, d1, d2;
    do_reset();
    i2c_start(); write_byte(8'hA0, k); write_byte(8'hFF, k);
    i2c_start(); write_byte(8'hA1, k);
    read_byte(1'b1, d0); read_byte(1'b1, d1); read_byte(1'b0, d2);
    i2c_stop(); q();
    compared++; if ({d0, d1, d2} !== 24'hFFFFFF) begin mismatched++; $display("FAIL rw_data: got %h expected ffffff", {d0, d1, d2}); end
    compared++; if (dut.ptr_q !== 8'h02) begin mismatched++; $display("FAIL rw_ptr: got %h expected 02", dut.ptr_q); end
  endtask

  task automatic test_reset_mid_read();
    logic k;
    int n;
    i2c_start(); write_byte(8'hA0, k); write_byte(8'h05, k); write_byte(8'h00, k); i2c_stop(); q();
    i2c_start(); write_byte(8'hA0, k); write_byte(8'h05, k);
    i2c_start(); write_byte(8'hA1, k);
    n = 0;
    while (sda_oe !== 1'b1 && n < 100) begin @(negedge sclk); n++; end
    compared++; if (sda_oe !== 1'b1) begin mismatched++; $display("FAIL rm_driving: got %b expected 1", sda_oe); end
    #2 reset = 1'b1;
    #1;
    compared++; if ({sda_oe, busy} !== 2'b00) begin mismatched++; $display("FAIL rm_outputs: got %b expected 00", {sda_oe, busy}); end
    compared++; if (dut.mem_q[8'h05] !== 8'hFF) begin mismatched++; $display("FAIL rm_mem: got %h expected ff", dut.mem_q[8'h05]); end
    scl_m = 1'b1; sda_m = 1'b1;
    repeat (4) @(negedge sclk);
    reset = 1'b0;
    q();
  endtask

  task automatic test_back_to_back();
    logic k0, k1, k2, k3, k4, k5;
    logic [7:0] d0, d1;
    i2c_start(); write_byte(8'hA0, k0); write_byte(8'h05, k1); write_byte(8'h81, k2); i2c_stop();
    i2c_start(); write_byte(8'hA0, k3); write_byte(8'h05, k4);
    i2c_start(); write_byte(8'hA1, k5); read_byte(1'b0, d0); i2c_stop();
    compared++; if ({k0, k1, k2, k3, k4, k5} !== 6'b111111) begin mismatched++; $display("FAIL bb_acks: got %b expected 111111", {k0, k1, k2, k3, k4, k5}); end
    compared++; if (d0 !== 8'h81) begin mismatched++; $display("FAIL bb_data: got %h expected 81", d0); end
    i2c_start(); write_byte(8'hA1, k0); read_byte(1'b0, d1); i2c_stop(); q();
    compared++; if ({k0, d1} !== {1'b1, 8'hFF}) begin mismatched++; $display("FAIL bb_cur_read: got %b/%h expected 1/ff", k0, d1); end
  endtask

  initial begin
    test_reset();
    test_byte_write();
    test_random_read();
    test_page_wrap();
    test_wp();
    test_mismatch();
    test_read_wrap();
    test_reset_mid_read();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
